// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, source-id tag and sizing helper for uart_tx_arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  localparam logic [3:0] SRCID_TAG = 4'hA;

  // Never returns 0 so single-entry configurations still get a 1-bit register.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX-FIFO write-side signals of uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic              en;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              write;
  logic [7:0]        wrdata;
  logic              isfull;

  modport master (
    output en, req, data, last, isfull,
    input  ack, gnt, busy, write, wrdata
  );

  modport slave (
    input  en, req, data, last, isfull,
    output ack, gnt, busy, write, wrdata
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search starting after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of the UART TX FIFO write port
// Optional source-id header byte per grant when UART_ARB_SRCID_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAX_PKT = 64
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(MAX_PKT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

  arb_state_t      state, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, win;
  logic [IW-1:0]   gidx_q, gidx_d, ptr_q, ptr_d, widx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, release_pkt;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .win (win),
    .idx (widx)
  );

  assign accept      = (state == ST_XFER) && bus.req[gidx_q] && !bus.isfull;
  // The MAX_PKT cut releases without LAST so the rest of the packet re-arbitrates.
  assign release_pkt = accept && (bus.last[gidx_q] || (cnt_q == CNT_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      gidx_q <= '0;
      ptr_q  <= IW'(NREQ - 1);
      cnt_q  <= '0;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      gidx_q <= gidx_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    bus.write  = 1'b0;
    bus.wrdata = '0;
    bus.ack    = '0;
    case (state)
      ST_IDLE: begin
        if (bus.en && (|bus.req)) begin
          gnt_d  = win;
          gidx_d = widx;
          cnt_d  = '0;
`ifdef UART_ARB_SRCID_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_SRCID_EN
      ST_HDR: begin
        bus.wrdata = {SRCID_TAG, 4'(gidx_q)};
        if (!bus.isfull) begin
          bus.write = 1'b1;
          state_d   = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        bus.wrdata = bus.data[8*gidx_q +: 8];
        if (accept) begin
          bus.write = 1'b1;
          bus.ack   = gnt_q;
          cnt_d     = cnt_q + CW'(1);
        end
        if (release_pkt) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = (state != ST_IDLE);

endmodule
